// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a valid/ready byte FIFO
// Define UART_RX_PARITY_EN for 8E1 frames with a parity check.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 4166,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic          rx_m, rx_s;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          expire, stop_hit, push_req, par_hit;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic          full, pop, push;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  assign expire   = (timer == '0);
  assign stop_hit = (state == STOP) && expire;
  assign push_req = stop_hit && rx_s;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (!expire) timer <= timer - 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          timer <= HALF_BIT;
        end
        START: if (expire) begin
          if (!rx_s) begin
            state   <= DATA;
            timer   <= FULL_BIT;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: if (expire) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          timer   <= FULL_BIT;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (expire) begin
          timer <= FULL_BIT;
          state <= STOP;
        end
`endif
        STOP: if (expire) state <= rx_s ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  // Even parity: the received parity bit must equal the XOR of the data bits.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) par_bad <= 1'b0;
    else if (state == PARITY && expire) par_bad <= rx_s ^ (^shreg);
  end
  assign par_hit = push_req && par_bad;
`else
  assign par_hit = 1'b0;
`endif

  assign fifo_count = wr_ptr - rd_ptr;
  assign rx_valid   = (wr_ptr != rd_ptr);
  assign full       = (fifo_count == DEPTH_C);
  assign pop        = rx_valid && rx_ready;
  assign push       = push_req && (!full || pop);
  assign rd_ptr_nxt = rd_ptr + (AW + 1)'(pop);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rx_data <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A byte landing in an (effectively) empty FIFO becomes the head directly.
      if (push && (wr_ptr == rd_ptr_nxt)) rx_data <= shreg;
      else if (pop) rx_data <= mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= stop_hit && !rx_s;
      overrun    <= push_req && full && !pop;
      parity_err <= par_hit;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at CLK_DIV=16, FIFO_DEPTH=8
module tb_uart_rx_fifo;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 171;
  localparam int PE_EXP    = 1;
`else
  localparam int STOP_EDGE = 155;
  localparam int PE_EXP    = 0;
`endif

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic       frame_err, overrun, parity_err;

  int checks = 0;
  int failures = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;

  uart_rx_fifo #(.CLK_DIV(16), .FIFO_DEPTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .rx_i(rx_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1)  n_fe <= n_fe + 1;
    if (overrun === 1'b1)    n_ov <= n_ov + 1;
    if (parity_err === 1'b1) n_pe <= n_pe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_low);
    rx_i = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      idle(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^d) ^ flip_par;
    idle(BIT);
`else
    rx_i = flip_par ? 1'b1 : 1'b1;
`endif
    if (stop_low) begin
      rx_i = 1'b0;
      idle(2 * BIT);
    end
    rx_i = 1'b1;
    idle(BIT);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    idle(3);
    wb_rst_i = 1'b0;
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_count", fifo_count, 0);
    chk("reset_flags", {frame_err, overrun, parity_err}, 3'b000);
    idle(4);

    send_frame(8'hA5, 1'b0, 1'b0);
    chk("single_valid", rx_valid, 1);
    chk("single_data", rx_data, 8'hA5);
    chk("single_count", fifo_count, 1);
    chk("single_errs", n_fe + n_ov + n_pe, 0);
    pop_one();
    chk("single_pop_valid", rx_valid, 0);
    chk("single_pop_count", fifo_count, 0);

    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    chk("fill_count", fifo_count, 8);
    chk("fill_overrun", n_ov, 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_data_%0d", i), rx_data, 8'(i));
      idle(1);
    end
    rx_ready = 1'b0;
    chk("drain_valid", rx_valid, 0);
    chk("drain_count", fifo_count, 0);

    send_frame(8'h3C, 1'b0, 1'b1);
    idle(4);
    chk("frame_err_cnt", n_fe, 1);
    chk("frame_err_count", fifo_count, 0);
    send_frame(8'h55, 1'b0, 1'b0);
    chk("after_fe_data", rx_data, 8'h55);
    chk("after_fe_count", fifo_count, 1);
    chk("after_fe_errs", n_fe, 1);
    pop_one();

    rx_i = 1'b0;
    idle(BIT / 4);
    rx_i = 1'b1;
    idle(3 * BIT);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_fe", n_fe, 1);

    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("full_count", fifo_count, 8);
    fork
      send_frame(8'h77, 1'b0, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    chk("pushpop_count", fifo_count, 8);
    chk("pushpop_overrun", n_ov, 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pushpop_data_%0d", i), rx_data, (i < 7) ? 8'h11 + 8'(i) : 8'h77);
      idle(1);
    end
    rx_ready = 1'b0;
    chk("pushpop_empty", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    chk("par_bad_cnt", n_pe, 1);
    chk("par_bad_data", rx_data, 8'h03);
    chk("par_bad_count", fifo_count, 1);
    pop_one();
    send_frame(8'h03, 1'b0, 1'b0);
    chk("par_ok_cnt", n_pe, 1);
    chk("par_ok_data", rx_data, 8'h03);
    pop_one();
`endif

    send_frame(8'h42, 1'b0, 1'b0);
    chk("pre_reset_count", fifo_count, 1);
    rx_i = 1'b0;
    idle(4 * BIT);
    rx_i = 1'b1;
    wb_rst_i = 1'b1;
    idle(1);
    wb_rst_i = 1'b0;
    chk("mid_reset_valid", rx_valid, 0);
    chk("mid_reset_data", rx_data, 8'h00);
    chk("mid_reset_count", fifo_count, 0);
    chk("mid_reset_flags", {frame_err, overrun, parity_err}, 3'b000);
    idle(3 * BIT);
    chk("mid_reset_quiet", rx_valid, 0);
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("recover_data", rx_data, 8'h5A);
    chk("recover_count", fifo_count, 1);
    chk("final_fe", n_fe, 1);
    chk("final_pe", n_pe, PE_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
